// File: rtl/mem_access_unit.sv
// Data-memory access stage: one bus transaction per load/store request, with byte-lane steering and load extension.
// Optional MEM_TIMEOUT_EN adds a bus wait counter that aborts after TIMEOUT_CYCLES wait cycles.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        done,
    output logic        busy,
    output logic        misalign,
    output logic        illegal,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;
    logic        lat_we;
    logic        fault;
    logic        chk_illegal;
    logic        chk_misalign;
    logic [31:0] load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        if (wr_req)
            chk_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        else
            chk_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        // Alignment is only meaningful for a recognised access size.
        chk_misalign = !chk_illegal &&
                       ((funct3[1:0] == 2'b01 && addr[0]) ||
                        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));
    end

    always_comb begin
        ld_byte  = bus_rdata[8*lat_addr[1:0] +: 8];
        ld_half  = bus_rdata[16*lat_addr[1] +: 16];
        load_ext = bus_rdata;
        case (lat_f3)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = lat_wdata;
        case (lat_f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << lat_addr[1:0];
                st_wdata = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {lat_addr[1], 1'b0};
                st_wdata = {2{lat_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = lat_wdata;
            end
        endcase
    end

    // A faulted request still spends one cycle in BUS with the bus held idle,
    // so every request reports done with the same minimum latency.
    assign bus_req   = (state == S_BUS) && !fault;
    assign bus_we    = bus_req && lat_we;
    assign bus_addr  = bus_req ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_we ? st_be : 4'b0000;
    assign bus_wdata = bus_we ? st_wdata : 32'd0;
    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       timeout_flag;
    assign timeout_err = timeout_flag;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_f3    <= 3'd0;
            lat_we    <= 1'b0;
            fault     <= 1'b0;
            rdata_out <= 32'd0;
            misalign  <= 1'b0;
            illegal   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt     <= 8'd0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_req || wr_req) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_f3    <= funct3;
                        lat_we    <= wr_req;
                        fault     <= chk_illegal || chk_misalign;
                        illegal   <= chk_illegal;
                        misalign  <= chk_misalign;
                        rdata_out <= 32'd0;
                        state     <= S_BUS;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt     <= 8'd0;
                        timeout_flag <= 1'b0;
`endif
                    end
                end
                S_BUS: begin
                    if (fault) begin
                        state <= S_DONE;
                    end else if (bus_ready) begin
                        state <= S_DONE;
                        if (!lat_we)
                            rdata_out <= load_ext;
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state        <= S_DONE;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
